// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared types and constants for the handshake skid buffer.
//   skid_state_t : EMPTY (no entries), BUSY (main slot full), FULL (main + skid)
//   LEVEL_W      : width of the occupancy output (0..2 entries)
// -----------------------------------------------------------------------------
package handshake_pkg;

    localparam int unsigned LEVEL_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage : handshake_pkg

// File: rtl/handshake_skid_buffer_if.sv
// -----------------------------------------------------------------------------
// handshake_skid_buffer_if
// Upstream/downstream valid-ready bundle for the skid buffer.
//   s_valid/s_ready/s_data : upstream handshake (into the buffer)
//   m_valid/m_ready/m_data : downstream handshake (out of the buffer)
//   level                  : entries currently held (0, 1 or 2)
// Modports:
//   slave  : the buffer's view (consumes s_*, produces m_* and level)
//   master : the surrounding environment's view (the opposite directions)
// -----------------------------------------------------------------------------
interface handshake_skid_buffer_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic                                s_valid;
    logic                                s_ready;
    logic [DATA_W-1:0]                   s_data;
    logic                                m_valid;
    logic                                m_ready;
    logic [DATA_W-1:0]                   m_data;
    logic [handshake_pkg::LEVEL_W-1:0]   level;

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output level
    );

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  level
    );

endinterface : handshake_skid_buffer_if

// File: rtl/handshake_slot.sv
// -----------------------------------------------------------------------------
// handshake_slot
// One storage entry of the skid buffer: a valid bit plus a DATA_W payload.
// Ports:
//   clk, resetn : clock and asynchronous active-low reset (clears valid + data)
//   load        : capture din and set valid (wins over clear)
//   clear       : drop valid; payload bits are left untouched
//   din         : payload to capture
//   valid, q    : slot occupancy and stored payload
// -----------------------------------------------------------------------------
module handshake_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule : handshake_slot

// File: rtl/handshake_skid_buffer.sv
// -----------------------------------------------------------------------------
// handshake_skid_buffer
// Two-entry valid/ready skid buffer. Full throughput with a registered s_ready,
// so there is no combinational path from m_ready back to s_ready.
// Ports:
//   clk    : single clock, all state on the rising edge
//   resetn : asynchronous active-low reset (empties both slots)
//   bus    : handshake_skid_buffer_if.slave (s_*, m_*, level)
// Configuration:
//   HANDSHAKE_SKID_PROTOCOL_CHECK_EN : when defined, compiles concurrent
//   protocol assertions (downstream stability, level range, no accept in FULL).
//   When undefined, no assertion code is present and behaviour is unchanged.
// -----------------------------------------------------------------------------
module handshake_skid_buffer
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    handshake_skid_buffer_if.slave   bus
);

    skid_state_t       state_q, state_d;
    logic              s_ready_q, s_ready_d;

    logic              s_fire, m_fire;

    logic              main_load, main_clear, main_valid;
    logic [DATA_W-1:0] main_din, main_data;
    logic              skid_load, skid_clear, skid_valid;
    logic [DATA_W-1:0] skid_data;

    assign s_fire = bus.s_valid & s_ready_q;
    assign m_fire = main_valid & bus.m_ready;

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_din   = bus.s_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (s_fire) begin
                    state_d   = BUSY;
                    main_load = 1'b1;
                end
            end
            BUSY: begin
                if (s_fire && m_fire) begin
                    main_load = 1'b1;
                end else if (s_fire) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (m_fire) begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                end
            end
            FULL: begin
                // s_ready is low here, so upstream data is never sampled.
                if (m_fire) begin
                    state_d    = BUSY;
                    main_load  = 1'b1;
                    main_din   = skid_data;
                    skid_clear = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Registered ready: decided from the next state so it lines up with
        // the occupancy seen on the following cycle.
        s_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
        end
    end

    handshake_slot #(.DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .resetn (resetn),
        .load   (main_load),
        .clear  (main_clear),
        .din    (main_din),
        .valid  (main_valid),
        .q      (main_data)
    );

    handshake_slot #(.DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .load   (skid_load),
        .clear  (skid_clear),
        .din    (bus.s_data),
        .valid  (skid_valid),
        .q      (skid_data)
    );

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = main_valid;
    assign bus.m_data  = main_data;
    assign bus.level   = LEVEL_W'(main_valid) + LEVEL_W'(skid_valid);

`ifdef HANDSHAKE_SKID_PROTOCOL_CHECK_EN
    property p_valid_hold;
        @(posedge clk) disable iff (!resetn)
            (bus.m_valid && !bus.m_ready) |=> bus.m_valid;
    endproperty

    property p_data_stable;
        @(posedge clk) disable iff (!resetn)
            (bus.m_valid && !bus.m_ready) |=> $stable(bus.m_data);
    endproperty

    property p_level_range;
        @(posedge clk) disable iff (!resetn)
            bus.level != 2'd3;
    endproperty

    property p_no_accept_when_full;
        @(posedge clk) disable iff (!resetn)
            !(s_fire && state_q == FULL);
    endproperty

    a_valid_hold: assert property (p_valid_hold)
        else $error("m_valid dropped while stalled");
    a_data_stable: assert property (p_data_stable)
        else $error("m_data changed while stalled");
    a_level_range: assert property (p_level_range)
        else $error("level reached 3");
    a_no_accept_when_full: assert property (p_no_accept_when_full)
        else $error("upstream transfer accepted in FULL");
`else
`endif

endmodule : handshake_skid_buffer

// File: tb/tb_handshake_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_handshake_skid_buffer
// Directed and randomized stimulus for handshake_skid_buffer, checked against a
// queue model: the buffer is a 2-deep FIFO whose ready reflects the occupancy
// at the start of the cycle and whose head is presented on m_data.
// -----------------------------------------------------------------------------
module tb_handshake_skid_buffer;

    localparam int unsigned DW = 8;

    logic clk;
    logic resetn;

    handshake_skid_buffer_if #(.DATA_W(DW)) bus ();

    handshake_skid_buffer #(.DATA_W(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [DW-1:0] model_q[$];   // contents held by the buffer, head first
    logic [DW-1:0] popped[$];    // DUT m_data captured at each downstream transfer

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs (just after the falling edge), check outputs
    // against the model, then advance the model across the rising edge.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr);
        int unsigned sz;
        logic s_acc;
        logic m_acc;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        #1;
        sz = model_q.size();
        check("s_ready", 64'(bus.s_ready), 64'(sz < 2));
        check("m_valid", 64'(bus.m_valid), 64'(sz > 0));
        check("level",   64'(bus.level),   64'(sz));
        if (sz > 0) check("m_data", 64'(bus.m_data), 64'(model_q[0]));
        s_acc = sv && (sz < 2);
        m_acc = mr && (sz > 0);
        if (m_acc) popped.push_back(bus.m_data);
        @(posedge clk);
        if (m_acc) void'(model_q.pop_front());
        if (s_acc) model_q.push_back(sd);
        @(negedge clk);
    endtask

    initial begin
        int unsigned n0;
        resetn      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_level",   64'(bus.level),   64'd0);
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_m_data",  64'(bus.m_data),  64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single transfer, one-cycle latency
        step(1'b1, 8'h11, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("lat_first_out", 64'(popped[popped.size()-1]), 64'h11);
        step(1'b0, 8'h00, 1'b1);
        check("lat_level0", 64'(bus.level), 64'd0);

        // Fill while stalled and hold for 10 cycles
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        check("fill_s_ready", 64'(bus.s_ready), 64'd0);
        check("fill_level",   64'(bus.level),   64'd2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'hEE, 1'b0);
            check("stall_m_data", 64'(bus.m_data), 64'h21);
        end

        // Drain FULL while a new word waits upstream
        n0 = popped.size();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h23, 1'b1);
        // 0x23 is still held upstream after acceptance; drop valid and drain.
        while (model_q.size() > 1) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        check("drain_first",  64'(popped[n0]),   64'h21);
        check("drain_second", 64'(popped[n0+1]), 64'h22);
        check("drain_third",  64'(popped[n0+2]), 64'h23);

        // Streaming at full rate
        popped.delete();
        model_q.delete();
        for (int i = 0; i < 64; i++) begin
            step(1'b1, DW'(i), 1'b1);
            if (i > 0) check("stream_level", 64'(bus.level), 64'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        check("stream_count", 64'(popped.size()), 64'd64);
        for (int i = 0; i < 64; i++) begin
            if (popped[i] !== DW'(i)) check("stream_order", 64'(popped[i]), 64'(i));
        end
        check("stream_last", 64'(popped[63]), 64'h3F);

        // Asynchronous reset while FULL
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        check("pre_rst_level", 64'(bus.level), 64'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_m_valid", 64'(bus.m_valid), 64'd0);
        check("arst_level",   64'(bus.level),   64'd0);
        check("arst_s_ready", 64'(bus.s_ready), 64'd1);
        check("arst_m_data",  64'(bus.m_data),  64'd0);
        model_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        popped.delete();
        step(1'b1, 8'h55, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_count", 64'(popped.size()), 64'd1);
        check("post_rst_data",  64'(popped[0]),     64'h55);

        // Random traffic, order checked against the model queue
        popped.delete();
        begin
            logic [DW-1:0] sent[$];
            for (int i = 0; i < 1000; i++) begin
                logic sv;
                logic mr;
                logic [DW-1:0] sd;
                sv = 1'($urandom_range(0, 1));
                mr = 1'($urandom_range(0, 1));
                sd = DW'($urandom);
                if (sv && model_q.size() < 2) sent.push_back(sd);
                step(sv, sd, mr);
            end
            while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
            check("rand_count", 64'(popped.size()), 64'(sent.size()));
            for (int i = 0; i < sent.size() && i < popped.size(); i++) begin
                if (popped[i] !== sent[i]) check("rand_order", 64'(popped[i]), 64'(sent[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_handshake_skid_buffer

// File: doc/handshake_skid_buffer.md
HANDSHAKE_SKID_BUFFER -- requirements
Module: handshake_skid_buffer

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (legal 1..64).
REQ-002 Port clk  input  1  single clock, all state on rising edge.
REQ-003 Port resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 Port s_valid  input  1  upstream payload valid.
REQ-005 Port s_ready  output  1  buffer can accept upstream payload.
REQ-006 Port s_data  input  DATA_W  upstream payload.
REQ-007 Port m_valid  output  1  downstream payload valid (feeds the valid/ready checker stage).
REQ-008 Port m_ready  input  1  downstream accepts payload.
REQ-009 Port m_data  output  DATA_W  downstream payload.
REQ-010 Port level  output  2  entries held: 0, 1 or 2.

Function
REQ-011 Transfer on either side SHALL occur only on a rising edge where valid and ready are both 1 (s_fire, m_fire).
REQ-012 FSM states SHALL be EMPTY (level 0), BUSY (main slot full, level 1) and FULL (main and skid slots full, level 2).
REQ-013 EMPTY: s_fire -> BUSY, main <= s_data; otherwise stay.
REQ-014 BUSY: s_fire and m_fire -> stay, main <= s_data; s_fire only -> FULL, skid <= s_data; m_fire only -> EMPTY; neither -> stay.
REQ-015 FULL: m_fire -> BUSY, main <= skid; otherwise stay; s_data ignored.
REQ-016 s_ready SHALL be a register output, 1 in EMPTY and BUSY, 0 in FULL; no combinational path from m_ready to s_ready.
REQ-017 m_valid SHALL be 1 in BUSY and FULL; m_data SHALL always be the main slot.
REQ-018 Latency s_fire -> m_valid SHALL be exactly 1 cycle; sustained throughput 1 transfer/cycle with m_ready held 1.
REQ-019 While m_valid=1 and m_ready=0, m_valid and m_data SHALL stay stable every cycle until m_fire (downstream stability rule).
REQ-020 Ordering SHALL be strict FIFO; no payload dropped or duplicated.
REQ-021 s_valid or m_ready at X SHALL be treated as 0 for state update only under simulation checks; RTL behaviour is defined for 0/1 only.

Reset
REQ-022 resetn=0 SHALL immediately force state EMPTY, m_valid 0, level 0, s_ready 1, m_data 0, skid 0.
REQ-023 Reset mid-operation SHALL discard both slots; first post-reset edge with s_valid=1 SHALL be accepted.

Configuration
REQ-024 With HANDSHAKE_SKID_PROTOCOL_CHECK_EN defined, the block SHALL include concurrent assertions: m_valid held through m_ready, m_data stable while stalled, level never 3, s_fire never in FULL; failures report via $error.
REQ-025 Without HANDSHAKE_SKID_PROTOCOL_CHECK_EN, no assertion code SHALL be compiled and RTL behaviour SHALL be identical.

Structure
REQ-026 Package handshake_pkg SHALL hold the skid_state_t enum (EMPTY, BUSY, FULL) and LEVEL_W = 2.
REQ-027 One sub-module handshake_slot (valid bit plus DATA_W register, load/clear inputs) SHALL be instantiated twice, for main and skid.

Verification
REQ-028 Reset then s_valid=1, s_data=0x11 one cycle, m_ready=1 -> m_valid=1, m_data=0x11 next cycle, level 1, then level 0.
REQ-029 m_ready=0, push 0x21 then 0x22 -> level 2, s_ready=0 on third edge, m_data held at 0x21 for 10 stalled cycles.
REQ-030 From FULL (0x21, 0x22), m_ready=1 with s_valid=1, s_data=0x23 -> outputs 0x21, 0x22, 0x23 in consecutive order, none lost.
REQ-031 Streaming 0x00..0x3F with m_ready=1, s_valid=1 -> 64 outputs on 64 consecutive cycles, level constant 1.
REQ-032 FULL state, resetn pulsed low mid-cycle -> m_valid=0, level 0, s_ready=1 without a clock edge; next push 0x55 emerges alone.
REQ-033 Random s_valid/m_ready toggling 1000 cycles, HANDSHAKE_SKID_PROTOCOL_CHECK_EN defined -> zero assertion failures, scoreboard order match.
